i2s_serialiser: RTL and testbench



---
 rtl/i2s_serialiser.sv | 77 +++++++
 tb/tb_i2s_serialiser.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/i2s_serialiser.sv
// Stereo I2S transmitter: 64-BCLK frame (two 32-BCLK slots), MSB first with one-BCLK delay,
// and a once-per-frame sample_req strobe that paces the upstream sample generators.
module i2s_serialiser #(
  parameter int DW        = 16,
  parameter int BCLK_HALF = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] audio_l,
  input  logic [DW-1:0] audio_r,
  input  logic          mute,
  output logic          sample_req,
  output logic          i2s_bclk,
  output logic          i2s_lrclk,
  output logic          i2s_sdata
);

  localparam int DIVW = $clog2(BCLK_HALF);

  logic [DIVW-1:0] r_div_cnt;
  logic [5:0]      r_bit_cnt;
  logic [DW-1:0]   r_l;
  logic [DW-1:0]   r_r;
  logic            r_bclk;
  logic            r_lrclk;
  logic            r_sdata;
  logic            r_req;

  logic            w_wrap;
  logic            w_fall;
  logic [5:0]      w_k;
  logic [31:0]     w_slot;
  logic            w_bit;

  assign w_wrap = (r_div_cnt == DIVW'(BCLK_HALF - 1));
  assign w_fall = w_wrap & r_bclk;
  assign w_k    = r_bit_cnt + 6'd1;

  // Slot word has a zero at position 0, then the sample MSB-first, then zero padding.
  assign w_slot = (w_k[5] ? 32'(r_r) : 32'(r_l)) << (31 - DW);
  assign w_bit  = w_slot[5'd31 - w_k[4:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_bit_cnt <= 6'd63;
      r_l       <= '0;
      r_r       <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
      r_sdata   <= 1'b0;
      r_req     <= 1'b0;
    end else begin
      r_div_cnt <= w_wrap ? '0 : r_div_cnt + DIVW'(1);
      r_req     <= w_fall && (w_k == 6'd32);
      if (w_wrap) begin
        r_bclk <= ~r_bclk;
      end
      if (w_fall) begin
        r_bit_cnt <= w_k;
        r_lrclk   <= w_k[5];
        r_sdata   <= w_bit;
        // Latch at k == 0; that bit is padding, so the new value is first used at k == 1.
        if (w_k == 6'd0) begin
          r_l <= mute ? '0 : audio_l;
          r_r <= mute ? '0 : audio_r;
        end
      end
    end
  end

  assign sample_req = r_req;
  assign i2s_bclk   = r_bclk;
  assign i2s_lrclk  = r_lrclk;
  assign i2s_sdata  = r_sdata;

endmodule

// File: tb/tb_i2s_serialiser.sv
// Bench for i2s_serialiser: per-cycle reference model derived from clk-edge count since reset
// release, plus an I2S word decoder on rising BCLK and a sine-generator integration run.
module tb_i2s_serialiser;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] audio_l;
  logic [DW-1:0] audio_r;
  logic          mute;
  logic          sample_req;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;

  logic [DW-1:0] stim_l;
  logic [DW-1:0] stim_r;
  logic          gen_mode;
  logic [DW-1:0] tab [48];
  int            gen_idx;

  int checks = 0;
  int errors = 0;

  i2s_serialiser #(.DW(DW), .BCLK_HALF(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .mute       (mute),
    .sample_req (sample_req),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sdata  (i2s_sdata)
  );

  always #5 clk = ~clk;

  assign audio_l = gen_mode ? tab[gen_idx] : stim_l;
  assign audio_r = gen_mode ? tab[gen_idx] : stim_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upstream generator: advances on the edge where sample_req is high.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) gen_idx <= 0;
    else if (sample_req) gen_idx <= (gen_idx + 1) % 48;
  end

  // Reference model: everything follows from n = clk edges since reset release.
  logic [DW-1:0] lat_l [$];
  logic [DW-1:0] lat_r [$];

  initial begin : monitor
    int n, f, k, fr, nrise, last_req, kr, frr;
    logic eb, el, es, eq, prev_bclk;
    logic [DW-1:0] shl, shr;
    n = 0; nrise = 0; last_req = -1; prev_bclk = 1'b0; shl = '0; shr = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        n = 0; nrise = 0; last_req = -1; prev_bclk = 1'b0;
        lat_l.delete(); lat_r.delete();
      end else begin
        n++;
        if (n % 16 == 0 && ((n / 16 - 1) % 64) == 0) begin
          lat_l.push_back(mute ? '0 : audio_l);
          lat_r.push_back(mute ? '0 : audio_r);
        end
      end
      #1;
      eb = 1'b0; el = 1'b0; es = 1'b0; eq = 1'b0;
      if (n > 0) begin
        eb = ((n / 8) % 2) == 1;
        f  = n / 16;
        if (f >= 1) begin
          k  = (f - 1) % 64;
          fr = (f - 1) / 64;
          el = (k >= 32);
          if (k >= 1 && k <= DW)            es = lat_l[fr][DW - k];
          else if (k >= 33 && k <= 32 + DW) es = lat_r[fr][DW - (k - 32)];
          eq = (n % 16 == 0) && (k == 32);
        end
      end
      chk("cycle{bclk,lr,sd,req}", {28'd0, i2s_bclk, i2s_lrclk, i2s_sdata, sample_req},
          {28'd0, eb, el, es, eq});
      if (reset_n && sample_req) begin
        if (last_req < 0) chk("first_req_edge", n, 528);
        else              chk("req_interval", n - last_req, 1024);
        last_req = n;
      end
      if (reset_n && i2s_bclk && !prev_bclk) begin
        nrise++;
        if (nrise >= 2) begin
          kr  = (nrise - 2) % 64;
          frr = (nrise - 2) / 64;
          if (kr >= 1 && kr <= DW) shl = {shl[DW-2:0], i2s_sdata};
          if (kr >= 33 && kr <= 32 + DW) shr = {shr[DW-2:0], i2s_sdata};
          if (kr == DW) begin
            chk("word_l", shl, lat_l[frr]);
            if (gen_mode) chk("sine_l", shl, tab[frr % 48]);
          end
          if (kr == 32 + DW) chk("word_r", shr, lat_r[frr]);
          chk("lrclk_at_bit", i2s_lrclk, (kr >= 32));
        end
      end
      prev_bclk = i2s_bclk;
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int i = 0; i < 48; i++)
      tab[i] = 16'($rtoi(32767.0 * $sin(2.0 * 3.14159265358979 * i / 48.0)));
    reset_n = 1'b0; mute = 1'b0; gen_mode = 1'b0;
    stim_l = 16'h8001; stim_r = 16'h7FFE;

    // Startup and bit order
    repeat (5) @(negedge clk);
    chk("reset_outputs", {i2s_bclk, i2s_lrclk, i2s_sdata, sample_req}, 4'b0);
    reset_n = 1'b1;
    $display("phase: startup and bit order 8001/7FFE");
    repeat (3 * 1024) @(negedge clk);

    // Random samples changing at random times mid-frame
    $display("phase: random samples");
    for (int i = 0; i < 12; i++) begin
      stim_l = 16'($urandom);
      stim_r = 16'($urandom);
      repeat ($urandom_range(150, 450)) @(negedge clk);
    end

    // Mute asserted mid-frame, then released
    $display("phase: mute");
    stim_l = 16'h5555; stim_r = 16'h5555;
    repeat (1024) @(negedge clk);
    repeat (400) @(negedge clk);
    mute = 1'b1;
    repeat (1024) @(negedge clk);
    mute = 1'b0;
    repeat (2 * 1024) @(negedge clk);

    // Async reset around bit 20, between clk edges
    $display("phase: async reset mid-frame");
    repeat (16 * 20) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {i2s_bclk, i2s_lrclk, i2s_sdata, sample_req}, 4'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * 1024) @(negedge clk);

    // Integration with the 48-sample sine generator
    $display("phase: sine integration");
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    gen_mode = 1'b1;
    reset_n = 1'b1;
    repeat (50 * 1024) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
